// File: rtl/rst_sequencer.sv
// ---------------------------------------------------------------------------
// rst_sequencer
//
// Purpose: takes the synchronous reset from the reset bridge and releases N
// downstream reset domains one after another. Release only starts once the
// PLL has reported lock. Loss of lock, or a software request, re-runs the
// whole sequence. The sequencer also reports why the last sequence started.
//
// Ports:
//   i_clk        clock
//   i_rst        synchronous active-high reset from the reset bridge
//   i_pll_lock   asynchronous PLL lock, synchronised here with two flops
//   i_sw_rst     single-cycle software re-sequence request (i_clk domain)
//   o_rst_stage  per-stage active-high reset; bit 0 is released first
//   o_ready      high once every stage is released and the FSM is in RUN
//   o_cause      cause of the last sequence start:
//                0 = i_rst, 1 = lock loss, 2 = software request
//
// Build option:
//   RST_SEQ_LOCK_FILTER_EN  when defined, synced lock must be low for
//                           LOCK_FILTER consecutive cycles before RELEASE/RUN
//                           treat it as lock loss. Undefined: one low cycle
//                           is enough.
// ---------------------------------------------------------------------------
module rst_sequencer #(
   parameter int unsigned N_STAGES    = 3,
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned STAGE_GAP   = 8,
   parameter int unsigned LOCK_FILTER = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_pll_lock,
   input  logic                i_sw_rst,
   output logic [N_STAGES-1:0] o_rst_stage,
   output logic                o_ready,
   output logic [1:0]          o_cause
);

   localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
   localparam int GAP_W  = $clog2(STAGE_GAP) + 1;
   localparam int IDX_W  = $clog2(N_STAGES) + 1;

   localparam logic [1:0] ST_ASSERT    = 2'd0;
   localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
   localparam logic [1:0] ST_RELEASE   = 2'd2;
   localparam logic [1:0] ST_RUN       = 2'd3;

   localparam logic [1:0] CAUSE_RST  = 2'd0;
   localparam logic [1:0] CAUSE_LOCK = 2'd1;
   localparam logic [1:0] CAUSE_SW   = 2'd2;

   localparam logic [N_STAGES-1:0] ALL_ASSERTED = {N_STAGES{1'b1}};

   if (N_STAGES < 1 || N_STAGES > 8 || HOLD_CYCLES < 1 || STAGE_GAP < 1 ||
       LOCK_FILTER < 1) begin : g_bad_params
      $error("rst_sequencer: parameter out of range");
   end

   logic                lk_s1_q, lk_s2_q;
   logic                lock_lost;
   logic [1:0]          state_q, state_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [N_STAGES-1:0] mask_q, mask_d;
   logic [1:0]          cause_q, cause_d;
   logic [N_STAGES-1:0] o_rst_stage_q;
   logic                o_ready_q;
   logic [1:0]          o_cause_q;

   // Two-flop synchroniser for the asynchronous lock input.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         lk_s1_q <= 1'b0;
         lk_s2_q <= 1'b0;
      end else begin
         lk_s1_q <= i_pll_lock;
         lk_s2_q <= lk_s1_q;
      end
   end

`ifdef RST_SEQ_LOCK_FILTER_EN
   localparam int FLT_W = $clog2(LOCK_FILTER) + 1;

   logic [FLT_W-1:0] flt_q, flt_d;

   // Counts consecutive low cycles of synced lock, saturating at LOCK_FILTER.
   always_comb begin
      flt_d = flt_q;
      if (lk_s2_q) begin
         flt_d = '0;
      end else if (flt_q != FLT_W'(LOCK_FILTER)) begin
         flt_d = flt_q + FLT_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         flt_q <= '0;
      end else begin
         flt_q <= flt_d;
      end
   end

   // flt_q holds the earlier low cycles, so this cycle is the LOCK_FILTER-th.
   assign lock_lost = !lk_s2_q && (flt_q >= FLT_W'(LOCK_FILTER - 1));
`else
   assign lock_lost = !lk_s2_q;
`endif

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      gap_d   = gap_q;
      idx_d   = idx_q;
      mask_d  = mask_q;
      cause_d = cause_q;

      case (state_q)
         ST_ASSERT: begin
            mask_d = ALL_ASSERTED;
            if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
               state_d = ST_WAIT_LOCK;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         ST_WAIT_LOCK: begin
            mask_d = ALL_ASSERTED;
            if (lk_s2_q) begin
               state_d = ST_RELEASE;
               gap_d   = '0;
               idx_d   = '0;
            end
         end
         ST_RELEASE: begin
            if (gap_q == GAP_W'(STAGE_GAP - 1)) begin
               gap_d = '0;
               idx_d = idx_q + IDX_W'(1);
               for (int k = 0; k < N_STAGES; k++) begin
                  if (idx_q == IDX_W'(k)) begin
                     mask_d[k] = 1'b0;
                  end
               end
               if (idx_q == IDX_W'(N_STAGES - 1)) begin
                  state_d = ST_RUN;
               end
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         ST_RUN: begin
            mask_d = '0;
         end
         default: begin
            state_d = ST_ASSERT;
            hold_d  = '0;
            mask_d  = ALL_ASSERTED;
         end
      endcase

      // Lock loss only matters once release has begun.
      if (lock_lost && (state_q == ST_RELEASE || state_q == ST_RUN)) begin
         state_d = ST_ASSERT;
         hold_d  = '0;
         mask_d  = ALL_ASSERTED;
         cause_d = CAUSE_LOCK;
      end

      // Software request is applied last so it wins over a same-cycle lock loss.
      if (i_sw_rst) begin
         state_d = ST_ASSERT;
         hold_d  = '0;
         mask_d  = ALL_ASSERTED;
         cause_d = CAUSE_SW;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_ASSERT;
         hold_q  <= '0;
         gap_q   <= '0;
         idx_q   <= '0;
         mask_q  <= ALL_ASSERTED;
         cause_q <= CAUSE_RST;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         gap_q   <= gap_d;
         idx_q   <= idx_d;
         mask_q  <= mask_d;
         cause_q <= cause_d;
      end
   end

   // Output register stage: outputs follow the FSM by one cycle. Ready waits
   // until the registered stage vector has itself reached all-released, so it
   // rises one cycle after the last stage output clears.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_rst_stage_q <= ALL_ASSERTED;
         o_ready_q     <= 1'b0;
         o_cause_q     <= CAUSE_RST;
      end else begin
         o_rst_stage_q <= mask_q;
         o_ready_q     <= (state_q == ST_RUN) && (o_rst_stage_q == '0);
         o_cause_q     <= cause_q;
      end
   end

   assign o_rst_stage = o_rst_stage_q;
   assign o_ready     = o_ready_q;
   assign o_cause     = o_cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rst_sequencer
//
// Bench for rst_sequencer at default parameters. The reference model tracks
// the sequence in terms of edge timestamps: the edge a sequence (re)started,
// the edge the sequencer saw lock after the hold, and from those the edge at
// which each stage must be released. Outputs are compared on every cycle
// after the first reset edge; directed scenarios also pin exact edge numbers.
// Honours RST_SEQ_LOCK_FILTER_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_rst_sequencer;

   localparam int N    = 3;
   localparam int HOLD = 16;
   localparam int GAP  = 8;
   localparam int LF   = 4;
`ifdef RST_SEQ_LOCK_FILTER_EN
   localparam int LOSS_LEN = LF;
`else
   localparam int LOSS_LEN = 1;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         lock;
   logic         sw;
   logic [N-1:0] rst_stage;
   logic         ready;
   logic [1:0]   cause;

   always #5 clk = ~clk;

   rst_sequencer #(
      .N_STAGES   (N),
      .HOLD_CYCLES(HOLD),
      .STAGE_GAP  (GAP),
      .LOCK_FILTER(LF)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_pll_lock (lock),
      .i_sw_rst   (sw),
      .o_rst_stage(rst_stage),
      .o_ready    (ready),
      .o_cause    (cause)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int           edge_n    = 0;   // absolute edge counter
   int           restart_e = 0;   // edge at which the current sequence restarted
   int           rel_e     = -1;  // edge at which lock was seen after the hold, -1 = not yet
   int           low_run   = 0;   // consecutive cycles the synced lock has been low
   logic         lk_prev1  = 1'b0;  // lock sampled one edge ago
   logic         lk_prev2  = 1'b0;  // lock sampled two edges ago
   logic [N-1:0] mask_m    = '1;    // stage vector the sequencer holds internally
   logic [1:0]   cause_m   = 2'd0;
   logic         run_p1    = 1'b0;  // all released as of the previous edge
   logic         run_p2    = 1'b0;  // all released as of two edges ago
   logic [N-1:0] exp_stage;
   logic         exp_ready;
   logic [1:0]   exp_cause;
   bit           chk_en    = 1'b0;

   // Called exactly at each rising edge with the inputs the DUT samples there.
   task automatic model_step();
      logic seen_lock;
      logic loss;
      edge_n++;
      seen_lock = lk_prev2;   // the FSM sees the value sampled two edges back
      if (rst) begin
         exp_stage = '1;
         exp_ready = 1'b0;
         exp_cause = 2'd0;
         restart_e = edge_n;
         rel_e     = -1;
         cause_m   = 2'd0;
         mask_m    = '1;
         run_p1    = 1'b0;
         run_p2    = 1'b0;
         low_run   = 0;
         lk_prev1  = 1'b0;
         lk_prev2  = 1'b0;
         chk_en    = 1'b1;
      end else begin
         low_run   = seen_lock ? 0 : low_run + 1;
         loss      = (rel_e >= 0) && !seen_lock && (low_run >= LOSS_LEN);
         exp_stage = mask_m;
         exp_cause = cause_m;
         exp_ready = run_p1 && run_p2;
         if (sw) begin
            restart_e = edge_n;
            rel_e     = -1;
            cause_m   = 2'd2;
         end else if (loss) begin
            restart_e = edge_n;
            rel_e     = -1;
            cause_m   = 2'd1;
         end else if (rel_e < 0 && edge_n >= restart_e + HOLD + 1 && seen_lock) begin
            rel_e = edge_n;
         end
         mask_m = '1;
         if (rel_e >= 0) begin
            for (int k = 0; k < N; k++) begin
               if (edge_n >= rel_e + (k + 1) * GAP) mask_m[k] = 1'b0;
            end
         end
         run_p2   = run_p1;
         run_p1   = (rel_e >= 0) && (edge_n >= rel_e + N * GAP);
         lk_prev2 = lk_prev1;
         lk_prev1 = lock;
      end
   endtask

   // Every-cycle comparison, on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("o_rst_stage", 8'(rst_stage), 8'(exp_stage));
         check("o_ready", 8'(ready), 8'(exp_ready));
         check("o_cause", 8'(cause), 8'(exp_cause));
      end
   end

   // ---------------- stimulus ----------------
   int ecount = 0;  // edges since the first edge with i_rst low (that edge is 0)

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      ecount++;
   endtask

   task automatic run_to(input int n);
      while (ecount < n) tick();
   endtask

   task automatic start_seq(input logic lk);
      rst  = 1'b1;
      lock = lk;
      sw   = 1'b0;
      repeat (5) tick();
      rst    = 1'b0;
      ecount = -1;
   endtask

   // Pins both the DUT and the model against hand-computed values.
   task automatic lit(input string nm, input logic [N-1:0] st, input logic rd,
                      input logic [1:0] cs);
      check({nm, " stage"}, 8'(rst_stage), 8'(st));
      check({nm, " ready"}, 8'(ready), 8'(rd));
      check({nm, " cause"}, 8'(cause), 8'(cs));
      check({nm, " model stage"}, 8'(exp_stage), 8'(st));
      check({nm, " model ready"}, 8'(exp_ready), 8'(rd));
      check({nm, " model cause"}, 8'(exp_cause), 8'(cs));
   endtask

   int sw_hold;
   int low_left;

   initial begin
      rst  = 1'b1;
      lock = 1'b1;
      sw   = 1'b0;

      // Power-up with steady lock.
      start_seq(1'b1);
      run_to(0);  lit("A_reset_release", 3'b111, 1'b0, 2'd0);
      run_to(24); lit("A_e24", 3'b111, 1'b0, 2'd0);
      run_to(25); lit("A_e25", 3'b110, 1'b0, 2'd0);
      run_to(33); lit("A_e33", 3'b100, 1'b0, 2'd0);
      run_to(41); lit("A_e41", 3'b000, 1'b0, 2'd0);
      run_to(42); lit("A_e42", 3'b000, 1'b1, 2'd0);

      // Lock arrives late: sampled high at edge 30, seen at edge 32.
      start_seq(1'b0);
      run_to(29); lock = 1'b1;
      run_to(40); lit("B_e40", 3'b111, 1'b0, 2'd0);
      run_to(41); lit("B_e41", 3'b110, 1'b0, 2'd0);
      run_to(49); lit("B_e49", 3'b100, 1'b0, 2'd0);
      run_to(57); lit("B_e57", 3'b000, 1'b0, 2'd0);
      run_to(58); lit("B_e58", 3'b000, 1'b1, 2'd0);

      // One-cycle lock glitch in RUN, then a four-cycle drop.
      run_to(60); lock = 1'b0;
      run_to(61); lock = 1'b1;
      run_to(63); lit("C_e63", 3'b000, 1'b1, 2'd0);
`ifdef RST_SEQ_LOCK_FILTER_EN
      run_to(64); lit("C_glitch_ignored", 3'b000, 1'b1, 2'd0);
      run_to(70); lock = 1'b0;
      run_to(74); lock = 1'b1;
      run_to(76); lit("C_e76", 3'b000, 1'b1, 2'd0);
      run_to(77); lit("C_drop4_abort", 3'b111, 1'b0, 2'd1);
      run_to(101); lit("C_e101", 3'b111, 1'b0, 2'd1);
      run_to(102); lit("C_e102", 3'b110, 1'b0, 2'd1);
`else
      run_to(64); lit("C_glitch_abort", 3'b111, 1'b0, 2'd1);
      run_to(70); lock = 1'b0;
      run_to(74); lock = 1'b1;
      run_to(88); lit("C_e88", 3'b111, 1'b0, 2'd1);
      run_to(89); lit("C_e89", 3'b110, 1'b0, 2'd1);
`endif
      run_to(130); lit("C_resequenced", 3'b000, 1'b1, 2'd1);

      // Software request after stage 0 is released.
      start_seq(1'b1);
      run_to(27); sw = 1'b1;
      run_to(28); sw = 1'b0;
      lit("D_e28", 3'b110, 1'b0, 2'd0);
      run_to(29); lit("D_sw_abort", 3'b111, 1'b0, 2'd2);
      run_to(53); lit("D_e53", 3'b111, 1'b0, 2'd2);
      run_to(54); lit("D_e54", 3'b110, 1'b0, 2'd2);
      run_to(75); lit("D_run", 3'b000, 1'b1, 2'd2);

      // i_rst together with i_sw_rst while in RUN.
      rst = 1'b1;
      sw  = 1'b1;
      run_to(76); lit("E_rst_wins", 3'b111, 1'b0, 2'd0);
      rst = 1'b0;
      sw  = 1'b0;

      // Random traffic: lock drops of varying length, sw pulses/holds, rare resets.
      start_seq(1'b1);
      sw_hold  = 0;
      low_left = 0;
      for (int i = 0; i < 4000; i++) begin
         tick();
         rst = ($urandom_range(0, 1499) == 0);
         if (sw_hold > 0) begin
            sw = 1'b1;
            sw_hold--;
         end else if ($urandom_range(0, 299) == 0) begin
            sw      = 1'b1;
            sw_hold = $urandom_range(0, 3);
         end else begin
            sw = 1'b0;
         end
         if (low_left > 0) begin
            lock = 1'b0;
            low_left--;
         end else if ($urandom_range(0, 119) == 0) begin
            lock     = 1'b0;
            low_left = $urandom_range(0, 6);
         end else begin
            lock = 1'b1;
         end
      end
      rst  = 1'b0;
      sw   = 1'b0;
      lock = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
